// File: rtl/swc_rd_sched.sv
`default_nettype none
// ============================================================================
// Module : swc_rd_sched
// Brief  : Switch cell read scheduler. Grants one output queue per cell,
//          streams the cell from the data SRAM, then retires the pointer.
// Rev    : 1.0  initial release
// ============================================================================
module swc_rd_sched #(
  parameter int NPORT   = 4,
  parameter int PTR_W   = 10,
  parameter int BEATS   = 4,
  parameter int RAM_LAT = 1,
  parameter int MODE    = 0
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NPORT-1:0]                 ptr_rdy,
  input  logic [16*NPORT-1:0]              ptr_dout,
  output logic [NPORT-1:0]                 ptr_ack,
  input  logic [NPORT-1:0]                 o_cell_bp,
  output logic                             sram_rd,
  output logic [PTR_W+$clog2(BEATS)-1:0]   sram_addr_b,
  output logic [NPORT-1:0]                 o_cell_fifo_wr,
  output logic                             o_cell_first,
  output logic                             o_cell_last,
  output logic [PTR_W-1:0]                 mc_addr,
  input  logic [3:0]                       mc_dout,
  output logic                             mc_wr,
  output logic [3:0]                       mc_din,
  output logic                             fq_wr,
  output logic [PTR_W-1:0]                 fq_din,
  output logic                             err_mc_zero
);

  localparam int c_bw = $clog2(BEATS);
  localparam int c_sw = $clog2(NPORT);
  localparam int c_dw = NPORT + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    MCUPD = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_sw-1:0]    r_rr;
  logic [c_sw-1:0]    r_sel;
  logic [PTR_W-1:0]   r_cur_addr;
  logic               r_cur_first;
  logic               r_cur_last;
  logic [c_dw-1:0]    r_dly [RAM_LAT];

  logic [NPORT-1:0]   w_req;
  logic [NPORT-1:0]   w_rot;
  logic [c_sw-1:0]    w_base;
  logic [c_sw-1:0]    w_off;
  logic [c_sw:0]      w_sum;
  logic [c_sw-1:0]    w_sel;
  logic [NPORT-1:0]   w_grant_oh;
  logic [NPORT-1:0]   w_sel_oh;
  logic [15:0]        w_ptr;
  logic [c_bw-1:0]    w_beat;
  logic [c_dw-1:0]    w_dly_in;
  logic               w_unused;

  assign w_req = ptr_rdy & ~o_cell_bp;

  // Rotate the request vector so the search always starts at bit 0; strict
  // priority is the same search with a fixed base of 0.
  assign w_base = (MODE == 0) ? r_rr : '0;
  assign w_rot  = NPORT'({w_req, w_req} >> w_base);

  always_comb begin
    w_off = '0;
    for (int i = NPORT-1; i >= 0; i--) begin
      if (w_rot[i]) w_off = c_sw'(i);
    end
  end

  assign w_sum = {1'b0, w_base} + {1'b0, w_off};
  assign w_sel = (w_sum >= (c_sw+1)'(NPORT)) ? c_sw'(w_sum - (c_sw+1)'(NPORT))
                                              : c_sw'(w_sum);

  always_comb begin
    w_ptr = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (w_sel == c_sw'(i)) w_ptr = ptr_dout[16*i +: 16];
    end
  end

  assign w_unused   = ^w_ptr;
  assign w_grant_oh = NPORT'(1) << w_sel;
  assign w_sel_oh   = NPORT'(1) << r_sel;
  assign w_beat     = sram_addr_b[c_bw-1:0];

  // Write strobe and flags for the beat being read now; delayed below to
  // line up with the SRAM read data.
  assign w_dly_in = sram_rd ? {w_sel_oh,
                               (w_beat == '0) & r_cur_first,
                               (w_beat == c_bw'(BEATS-1)) & r_cur_last}
                            : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RAM_LAT; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= w_dly_in;
      for (int i = 1; i < RAM_LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  assign o_cell_fifo_wr = r_dly[RAM_LAT-1][c_dw-1:2];
  assign o_cell_first   = r_dly[RAM_LAT-1][1];
  assign o_cell_last    = r_dly[RAM_LAT-1][0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_rr        <= '0;
      r_sel       <= '0;
      r_cur_addr  <= '0;
      r_cur_first <= 1'b0;
      r_cur_last  <= 1'b0;
      ptr_ack     <= '0;
      sram_rd     <= 1'b0;
      sram_addr_b <= '0;
      mc_addr     <= '0;
      mc_wr       <= 1'b0;
      mc_din      <= '0;
      fq_wr       <= 1'b0;
      fq_din      <= '0;
      err_mc_zero <= 1'b0;
    end else begin
      ptr_ack <= '0;
      mc_wr   <= 1'b0;
      mc_din  <= '0;
      fq_wr   <= 1'b0;
      fq_din  <= '0;
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_sel       <= w_sel;
            r_cur_addr  <= w_ptr[PTR_W-1:0];
            r_cur_first <= w_ptr[14];
            r_cur_last  <= w_ptr[15];
            ptr_ack     <= w_grant_oh;
            if (MODE == 0) r_rr <= (w_sel == c_sw'(NPORT-1)) ? '0 : w_sel + 1'b1;
            mc_addr     <= w_ptr[PTR_W-1:0];
            sram_rd     <= 1'b1;
            sram_addr_b <= {w_ptr[PTR_W-1:0], {c_bw{1'b0}}};
            r_state     <= READ;
          end
        end
        READ: begin
          if (w_beat == c_bw'(BEATS-1)) begin
            // mc_addr has been stable since the first READ cycle, so mc_dout
            // is valid here (BEATS >= 2) and the write lands during MCUPD.
            sram_rd <= 1'b0;
            r_state <= MCUPD;
            mc_wr   <= 1'b1;
            if (mc_dout <= 4'd1) begin
              fq_wr  <= 1'b1;
              fq_din <= r_cur_addr;
              if (mc_dout == 4'd0) err_mc_zero <= 1'b1;
            end else begin
              mc_din <= mc_dout - 4'd1;
            end
          end else begin
            sram_addr_b <= sram_addr_b + 1'b1;
          end
        end
        MCUPD:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_swc_rd_sched.sv
`default_nettype none
// Bench for swc_rd_sched: a round-robin/RAM_LAT 1 and a strict-priority/RAM_LAT 3
// instance share stimulus and are scored each cycle against a transaction model.
module tb_swc_rd_sched;

  localparam int NP = 4;
  localparam int PW = 10;
  localparam int BT = 4;
  localparam int AW = PW + 2;

  typedef struct packed {
    logic [NP-1:0] ack;
    logic          rd;
    logic [AW-1:0] addr;
    logic [NP-1:0] wr;
    logic          first;
    logic          last;
    logic          mav;
    logic [PW-1:0] ma;
    logic          mcwr;
    logic [3:0]    mcdin;
    logic          fq;
    logic [PW-1:0] fqdin;
  } exp_t;

  typedef struct {
    logic [NP-1:0] rdy;
    logic [NP-1:0] bpv;
    logic [15:0]   ptr;
    logic [3:0]    mcv;
    int            sel0;
    int            sel1;
    logic [3:0]    din;
    logic          fq;
    logic          err;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  logic [NP-1:0]    ptr_rdy;
  logic [NP-1:0]    bp;
  logic [16*NP-1:0] ptr_dout;

  logic [NP-1:0] ack   [2];
  logic          rd    [2];
  logic [AW-1:0] addr  [2];
  logic [NP-1:0] wr    [2];
  logic          first [2];
  logic          last  [2];
  logic [PW-1:0] mca   [2];
  logic [3:0]    mcd   [2];
  logic          mcwr  [2];
  logic [3:0]    mcdin [2];
  logic          fqwr  [2];
  logic [PW-1:0] fqdin [2];
  logic          err   [2];

  logic [3:0] mc_mem [1<<PW];
  exp_t       ex [2][32];
  int         rr [2];
  int         nf [2];
  int         errc [2];
  int         cyc;
  int         errors;
  int         checks;

  swc_rd_sched #(.NPORT(NP), .PTR_W(PW), .BEATS(BT), .RAM_LAT(1), .MODE(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .ptr_rdy(ptr_rdy), .ptr_dout(ptr_dout), .ptr_ack(ack[0]),
    .o_cell_bp(bp), .sram_rd(rd[0]), .sram_addr_b(addr[0]), .o_cell_fifo_wr(wr[0]),
    .o_cell_first(first[0]), .o_cell_last(last[0]), .mc_addr(mca[0]), .mc_dout(mcd[0]),
    .mc_wr(mcwr[0]), .mc_din(mcdin[0]), .fq_wr(fqwr[0]), .fq_din(fqdin[0]),
    .err_mc_zero(err[0]));

  swc_rd_sched #(.NPORT(NP), .PTR_W(PW), .BEATS(BT), .RAM_LAT(3), .MODE(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .ptr_rdy(ptr_rdy), .ptr_dout(ptr_dout), .ptr_ack(ack[1]),
    .o_cell_bp(bp), .sram_rd(rd[1]), .sram_addr_b(addr[1]), .o_cell_fifo_wr(wr[1]),
    .o_cell_first(first[1]), .o_cell_last(last[1]), .mc_addr(mca[1]), .mc_dout(mcd[1]),
    .mc_wr(mcwr[1]), .mc_din(mcdin[1]), .fq_wr(fqwr[1]), .fq_din(fqdin[1]),
    .err_mc_zero(err[1]));

  always #5 clk = ~clk;

  // Refcount RAM, read latency 1; contents are only changed by the bench.
  always @(posedge clk) begin
    mcd[0] <= mc_mem[mca[0]];
    mcd[1] <= mc_mem[mca[1]];
  end

  task automatic chk(input string nm, input bit d, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h expected=%0h", nm, d, cyc, act, expv);
    end
  endtask

  function automatic int oh2i(input logic [NP-1:0] v);
    oh2i = -1;
    for (int i = 0; i < NP; i++) if (v[i]) oh2i = i;
  endfunction

  // A grant at edge k owns the scheduler for BT+2 cycles: reads at k..k+BT-1,
  // writes LAT later, refcount/free-queue update at k+BT.
  task automatic model_step(input bit d);
    logic [NP-1:0] req;
    logic [1:0]    ix;
    logic [15:0]   p;
    logic [3:0]    m;
    int            sel;
    int            lat;
    req = ptr_rdy & ~bp;
    if (cyc < nf[d] || req == '0) return;
    lat = d ? 3 : 1;
    sel = -1;
    for (int i = 0; i < NP; i++) begin
      ix = 2'((d ? 0 : rr[d]) + i);
      if (sel < 0 && req[ix]) sel = int'(ix);
    end
    p = 16'(ptr_dout >> (16*sel));
    m = mc_mem[p[PW-1:0]];
    ex[d][5'(cyc)].ack = NP'(1) << sel;
    for (int b = 0; b < BT; b++) begin
      ex[d][5'(cyc+b)].rd   = 1'b1;
      ex[d][5'(cyc+b)].addr = {p[PW-1:0], 2'(b)};
      ex[d][5'(cyc+b+lat)].wr    = NP'(1) << sel;
      ex[d][5'(cyc+b+lat)].first = (b == 0) && p[14];
      ex[d][5'(cyc+b+lat)].last  = (b == BT-1) && p[15];
    end
    for (int b = 0; b <= BT; b++) begin
      ex[d][5'(cyc+b)].mav = 1'b1;
      ex[d][5'(cyc+b)].ma  = p[PW-1:0];
    end
    ex[d][5'(cyc+BT)].mcwr  = 1'b1;
    ex[d][5'(cyc+BT)].mcdin = (m <= 1) ? 4'd0 : m - 4'd1;
    ex[d][5'(cyc+BT)].fq    = (m <= 1);
    ex[d][5'(cyc+BT)].fqdin = (m <= 1) ? p[PW-1:0] : '0;
    if (m == 0 && errc[d] < 0) errc[d] = cyc + BT;
    if (!d) rr[d] = (sel + 1) % NP;
    nf[d] = cyc + BT + 2;
  endtask

  task automatic check_win(input bit d);
    exp_t e;
    logic ee;
    e  = ex[d][5'(cyc)];
    ee = (errc[d] >= 0) && (cyc >= errc[d]);
    chk("strobes", d, {ack[d], rd[d], wr[d], first[d], last[d], mcwr[d], fqwr[d], err[d]},
                      {e.ack, e.rd, e.wr, e.first, e.last, e.mcwr, e.fq, ee});
    if (e.rd)   chk("sram_addr_b", d, addr[d], e.addr);
    if (e.mav)  chk("mc_addr", d, mca[d], e.ma);
    if (e.mcwr) chk("mc_din", d, mcdin[d], e.mcdin);
    if (e.fq)   chk("fq_din", d, fqdin[d], e.fqdin);
    ex[d][5'(cyc)] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rstn) begin
      model_step(1'b0);
      model_step(1'b1);
    end
    @(negedge clk);
    check_win(1'b0);
    check_win(1'b1);
  endtask

  task automatic apply_reset(input bit chk_now);
    rstn = 1'b0;
    #1;
    if (chk_now) begin
      for (int d = 0; d < 2; d++)
        chk("reset_outputs", 1'(d), {ack[d], rd[d], addr[d], wr[d], first[d], last[d], mca[d],
                                    mcwr[d], mcdin[d], fqwr[d], fqdin[d], err[d]}, 64'd0);
    end
    for (int d = 0; d < 2; d++) begin
      rr[d] = 0; nf[d] = 0; errc[d] = -1;
      for (int i = 0; i < 32; i++) ex[d][i] = '0;
    end
    tick();
    tick();
    rstn = 1'b1;
  endtask

  vec_t tv [6];
  int   g0, g1, nfst, nlst, n, t0, r1, w1, nbad;
  int   gs [8];
  int   gt [8];
  logic [3:0] din0;
  logic fq0;

  initial begin
    errors = 0; checks = 0; cyc = 0;
    ptr_rdy = '0; bp = '0; ptr_dout = '0;
    for (int i = 0; i < (1<<PW); i++)
      mc_mem[i] = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 4));

    //         rdy      bp       ptr       mc    sel0 sel1 din   fq    err
    tv[0] = '{4'b1111, 4'b0000, 16'hC005, 4'd1, 0, 0, 4'd0, 1'b1, 1'b0};
    tv[1] = '{4'b0100, 4'b0000, 16'hC005, 4'd1, 2, 2, 4'd0, 1'b1, 1'b0};
    tv[2] = '{4'b1010, 4'b0000, 16'h0123, 4'd3, 1, 1, 4'd2, 1'b0, 1'b0};
    tv[3] = '{4'b1010, 4'b0010, 16'h4077, 4'd2, 3, 3, 4'd1, 1'b0, 1'b0};
    tv[4] = '{4'b1111, 4'b0111, 16'h8200, 4'd0, 3, 3, 4'd0, 1'b1, 1'b1};
    tv[5] = '{4'b0110, 4'b0100, 16'h03FF, 4'd5, 1, 1, 4'd4, 1'b0, 1'b0};

    @(negedge clk);
    apply_reset(1'b1);

    for (int t = 0; t < 6; t++) begin
      apply_reset(1'b0);
      ptr_rdy  = tv[t].rdy;
      bp       = tv[t].bpv;
      ptr_dout = {NP{tv[t].ptr}};
      mc_mem[tv[t].ptr[PW-1:0]] = tv[t].mcv;
      g0 = -1; g1 = -1; nfst = 0; nlst = 0; din0 = 4'hF; fq0 = 1'b0;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (c == 0) ptr_rdy = '0;
        if (g0 < 0 && ack[0] != '0) g0 = oh2i(ack[0]);
        if (g1 < 0 && ack[1] != '0) g1 = oh2i(ack[1]);
        if (mcwr[0]) din0 = mcdin[0];
        fq0  = fq0 | fqwr[0];
        nfst += int'(first[0]);
        nlst += int'(last[0]);
      end
      chk("tv_sel_rr", 1'b0, 64'(g0), 64'(tv[t].sel0));
      chk("tv_sel_prio", 1'b1, 64'(g1), 64'(tv[t].sel1));
      chk("tv_mc_din", 1'b0, din0, tv[t].din);
      chk("tv_fq_wr", 1'b0, fq0, tv[t].fq);
      chk("tv_err_sticky", 1'b1, err[1], tv[t].err);
      chk("tv_flags", 1'b0, {nfst[7:0], nlst[7:0]}, {7'd0, tv[t].ptr[14], 7'd0, tv[t].ptr[15]});
    end

    // Round-robin sweep with all queues ready: 0,1,2,3,0 every 6 cycles.
    apply_reset(1'b0);
    ptr_rdy  = 4'b1111; bp = '0;
    ptr_dout = {16'h8033, 16'h4022, 16'hC011, 16'h0000};
    n = 0; r1 = -1; w1 = -1;
    for (int c = 0; c < 28; c++) begin
      tick();
      if (ack[0] != '0 && n < 8) begin gs[n] = oh2i(ack[0]); gt[n] = cyc; n++; end
      if (r1 < 0 && rd[1]) r1 = cyc;
      if (w1 < 0 && wr[1] != '0) w1 = cyc;
    end
    chk("rr_grant_count", 1'b0, 64'(n), 64'd5);
    for (int i = 0; i < 5; i++) chk("rr_order", 1'b0, 64'(gs[i]), 64'(i % NP));
    chk("rr_ack_period", 1'b0, 64'(gt[1] - gt[0]), 64'd6);
    chk("lat3_write_lag", 1'b1, 64'(w1 - r1), 64'd3);

    // Strict priority keeps picking port 1 over port 3.
    apply_reset(1'b0);
    ptr_rdy = 4'b1010;
    n = 0; nbad = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (ack[1] != '0) begin n++; if (ack[1] != 4'b0010) nbad++; end
    end
    chk("prio_grants", 1'b1, 64'(n), 64'd5);
    chk("prio_never_port3", 1'b1, 64'(nbad), 64'd0);

    // Backpressure rising mid-cell does not truncate it nor allow a regrant.
    apply_reset(1'b0);
    ptr_rdy = 4'b0001; bp = '0;
    n = 0; nbad = 0;
    tick(); n += int'(ack[0] != '0); nbad += int'(wr[0] != '0);
    tick(); n += int'(ack[0] != '0); nbad += int'(wr[0] != '0);
    bp = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      n += int'(ack[0] != '0);
      nbad += int'(wr[0] != '0);
    end
    chk("bp_writes", 1'b0, 64'(nbad), 64'd4);
    chk("bp_no_regrant", 1'b0, 64'(n), 64'd1);
    bp = '0;

    // Reset in the middle of READ abandons the cell.
    apply_reset(1'b0);
    ptr_rdy = 4'b0001;
    tick();
    tick();
    ptr_rdy = '0;
    apply_reset(1'b1);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      n += int'(mcwr[0]) + int'(fqwr[0]) + int'(mcwr[1]) + int'(fqwr[1]);
    end
    chk("reset_no_update", 1'b0, 64'(n), 64'd0);

    // Random traffic scored by the model.
    t0 = cyc;
    while (cyc - t0 < 1500) begin
      ptr_rdy  = NP'($urandom);
      bp       = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
      ptr_dout = {$urandom, $urandom};
      if ($urandom_range(0, 399) == 0) apply_reset(1'b1);
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
